// File: rtl/ctu_clsp_sync_xfer.sv
// ----------------------------------------------------------------------------
// ctu_clsp_sync_xfer
//
// Crossing buffer on the cmp_clk side of a ratio-synchronous clock pair. The
// clock-sync pulse generator says which cmp cycles are safe to touch the slow
// domain. tx_sync marks a safe cycle to update slow_tx_*. rx_sync marks a safe
// cycle to sample slow_rx_*. Because of this, no asynchronous synchronizers are
// needed.
//
// Tx path: cmp-side words go into a small FIFO. The head word is launched onto
// a held output register only on a tx_sync cycle. The slow domain may sample
// slow_tx_* at any point between two tx_sync pulses, so these outputs must
// never move on any other cycle.
//
// Rx path: on an rx_sync cycle with slow_rx_vld set, the slow word is captured.
// It is then presented as a single-cycle cmp_rx_vld pulse.
//
// Ports
//   cmp_clk       in   single clock for all state
//   cmp_rst_l     in   synchronous active-low reset
//   tx_sync       in   safe cycle to update slow_tx_*
//   rx_sync       in   safe cycle to sample slow_rx_*
//   xfer_flush    in   clears tx FIFO, slow_tx_vld and tx_ovfl_err
//   cmp_tx_vld    in   push request
//   cmp_tx_data   in   push data [WIDTH]
//   cmp_tx_rdy    out  FIFO not full
//   slow_tx_vld   out  launched word valid (held between tx_sync)
//   slow_tx_data  out  launched word [WIDTH] (held between tx_sync)
//   slow_rx_vld   in   slow-domain word valid
//   slow_rx_data  in   slow-domain word [WIDTH]
//   cmp_rx_vld    out  one-cycle pulse, captured word valid
//   cmp_rx_data   out  captured word [WIDTH], held until next capture
//   tx_fifo_cnt   out  FIFO occupancy [PTR_W+1], 0..DEPTH
//   tx_ovfl_err   out  sticky, push attempted while full
// ----------------------------------------------------------------------------
module ctu_clsp_sync_xfer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             cmp_clk,
    input  logic             cmp_rst_l,
    input  logic             tx_sync,
    input  logic             rx_sync,
    input  logic             xfer_flush,
    input  logic             cmp_tx_vld,
    input  logic [WIDTH-1:0] cmp_tx_data,
    output logic             cmp_tx_rdy,
    output logic             slow_tx_vld,
    output logic [WIDTH-1:0] slow_tx_data,
    input  logic             slow_rx_vld,
    input  logic [WIDTH-1:0] slow_rx_data,
    output logic             cmp_rx_vld,
    output logic [WIDTH-1:0] cmp_rx_data,
    output logic [PTR_W:0]   tx_fifo_cnt,
    output logic             tx_ovfl_err
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------------
    // Tx FIFO storage and control
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full and empty are decoded from the registered count only. This keeps
    // cmp_tx_rdy free of any combinational path from the inputs.
    assign full        = (cnt == FULL_CNT);
    assign empty       = (cnt == '0);
    assign cmp_tx_rdy  = ~full;
    assign tx_fifo_cnt = cnt;

    // Flush has priority, so a push or pop in a flush cycle is discarded.
    // Pop only looks at the registered count. A word written this cycle
    // therefore cannot launch before the next tx_sync (no bypass).
    assign push = cmp_tx_vld & ~full & ~xfer_flush;
    assign pop  = tx_sync & ~empty & ~xfer_flush;

    // Data storage is deliberately left unreset. The pointers define what is
    // valid, so stale entries are never observable.
    always_ff @(posedge cmp_clk) begin
        if (push) begin
            mem[wr_ptr] <= cmp_tx_data;
        end
    end

    always_ff @(posedge cmp_clk) begin
        if (!cmp_rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (xfer_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Launch register: only a tx_sync (or a flush/reset) may change it
    // ------------------------------------------------------------------------
    always_ff @(posedge cmp_clk) begin
        if (!cmp_rst_l) begin
            slow_tx_vld  <= 1'b0;
            slow_tx_data <= '0;
        end else if (xfer_flush) begin
            // Data is held so the slow side never sees a glitch on the bus.
            slow_tx_vld <= 1'b0;
        end else if (tx_sync) begin
            slow_tx_vld <= pop;
            if (pop) begin
                slow_tx_data <= mem[rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Overflow flag: sticky until flush or reset; the offending word is lost
    // ------------------------------------------------------------------------
    always_ff @(posedge cmp_clk) begin
        if (!cmp_rst_l) begin
            tx_ovfl_err <= 1'b0;
        end else if (xfer_flush) begin
            tx_ovfl_err <= 1'b0;
        end else if (cmp_tx_vld && full) begin
            tx_ovfl_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Rx capture: independent of the tx path and of flush
    // ------------------------------------------------------------------------
    logic rx_take;

    assign rx_take = rx_sync & slow_rx_vld;

    always_ff @(posedge cmp_clk) begin
        if (!cmp_rst_l) begin
            cmp_rx_vld  <= 1'b0;
            cmp_rx_data <= '0;
        end else begin
            cmp_rx_vld <= rx_take;
            if (rx_take) begin
                cmp_rx_data <= slow_rx_data;
            end
        end
    end

endmodule

// File: tb/tb_ctu_clsp_sync_xfer.sv
module tb_ctu_clsp_sync_xfer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             tx_sync, rx_sync, flush, tvld, srx_vld;
    logic [WIDTH-1:0] tdata, srx_data;
    logic             rdy, stx_vld, crx_vld, err;
    logic [WIDTH-1:0] stx_data, crx_data;
    logic [PTR_W:0]   cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue for the FIFO plus the visible output registers.
    logic [WIDTH-1:0] q[$];
    logic             m_tvld, m_err, m_rvld;
    logic [WIDTH-1:0] m_tdata, m_rdata;

    always #5 clk = ~clk;

    ctu_clsp_sync_xfer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .cmp_clk     (clk),
        .cmp_rst_l   (rst_l),
        .tx_sync     (tx_sync),
        .rx_sync     (rx_sync),
        .xfer_flush  (flush),
        .cmp_tx_vld  (tvld),
        .cmp_tx_data (tdata),
        .cmp_tx_rdy  (rdy),
        .slow_tx_vld (stx_vld),
        .slow_tx_data(stx_data),
        .slow_rx_vld (srx_vld),
        .slow_rx_data(srx_data),
        .cmp_rx_vld  (crx_vld),
        .cmp_rx_data (crx_data),
        .tx_fifo_cnt (cnt),
        .tx_ovfl_err (err)
    );

    task automatic model_step();
        int sz;
        if (!rst_l) begin
            q.delete();
            m_tvld = 0; m_tdata = '0; m_err = 0; m_rvld = 0; m_rdata = '0;
        end else begin
            if (flush) begin
                q.delete();
                m_tvld = 0;
                m_err  = 0;
            end else begin
                sz = q.size();
                if (tvld && sz == DEPTH) m_err = 1;
                if (tx_sync) begin
                    if (sz > 0) begin
                        m_tdata = q.pop_front();
                        m_tvld  = 1;
                    end else begin
                        m_tvld = 0;
                    end
                end
                if (tvld && sz < DEPTH) q.push_back(tdata);
            end
            m_rvld = rx_sync && srx_vld;
            if (m_rvld) m_rdata = srx_data;
        end
    endtask

    // One clock: inputs already set, advance model at the edge, sample at +1.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst_l = 1; tx_sync = 0; rx_sync = 0; flush = 0;
        tvld = 0; tdata = '0; srx_vld = 0; srx_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_l = 0;
        cyc(); cyc();
        rst_l = 1;
        cyc();
        total++; if (cnt !== 0)        begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        total++; if (rdy !== 1'b1)     begin bad++; $display("FAIL reset_rdy got=%0b exp=1", rdy); end
        total++; if ({stx_vld, stx_data, crx_vld, crx_data, err} !== '0)
                 begin bad++; $display("FAIL reset_outs got=%0b/%h/%0b/%h/%0b exp=0", stx_vld, stx_data, crx_vld, crx_data, err); end
    endtask

    task automatic test_launch();
        logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
        int p = 0;
        idle();
        for (int i = 0; i < 3; i++) begin
            tvld = 1; tdata = vals[i];
            cyc();
            total++; if (cnt !== (PTR_W+1)'(i+1)) begin bad++; $display("FAIL launch_cnt got=%0d exp=%0d", cnt, i+1); end
        end
        idle();
        for (int k = 0; k < 16; k++) begin
            tx_sync = (k % 4 == 0);
            cyc();
            if (tx_sync) begin
                total++;
                if (stx_vld !== (p < 3) || stx_data !== vals[(p < 3) ? p : 2]) begin
                    bad++; $display("FAIL launch_pulse%0d got=%0b/%h exp=%0b/%h", p, stx_vld, stx_data, p < 3, vals[(p < 3) ? p : 2]);
                end
                p++;
            end else begin
                total++;
                if (stx_vld !== m_tvld || stx_data !== m_tdata) begin
                    bad++; $display("FAIL launch_hold got=%0b/%h exp=%0b/%h", stx_vld, stx_data, m_tvld, m_tdata);
                end
            end
            tx_sync = 0;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] w[4];
        idle();
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            tvld = 1; tdata = w[i];
            cyc();
        end
        total++; if (cnt !== 3'd4 || rdy !== 1'b0) begin bad++; $display("FAIL ovf_full got=%0d/%0b exp=4/0", cnt, rdy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", err); end
        tdata = 8'hAA;
        cyc();
        total++; if (err !== 1'b1 || cnt !== 3'd4) begin bad++; $display("FAIL ovf_set got=%0b/%0d exp=1/4", err, cnt); end
        idle();
        for (int i = 0; i < 5; i++) begin
            tx_sync = 1; cyc(); tx_sync = 0;
            total++;
            if (i < 4 && (stx_vld !== 1'b1 || stx_data !== w[i])) begin
                bad++; $display("FAIL ovf_drain%0d got=%0b/%h exp=1/%h", i, stx_vld, stx_data, w[i]);
            end else if (i == 4 && (stx_vld !== 1'b0 || stx_data !== w[3])) begin
                bad++; $display("FAIL ovf_empty got=%0b/%h exp=0/%h", stx_vld, stx_data, w[3]);
            end
            cyc();
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", err); end
        flush = 1; cyc(); flush = 0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", err); end
    endtask

    task automatic test_wrap();
        logic [7:0] w[6];
        idle();
        for (int i = 0; i < 6; i++) w[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 2; i++) begin tvld = 1; tdata = w[i]; cyc(); end
        for (int i = 2; i < 6; i++) begin
            tvld = 1; tdata = w[i]; tx_sync = 1;
            cyc();
            total++;
            if (cnt !== 3'd2 || stx_vld !== 1'b1 || stx_data !== w[i-2]) begin
                bad++; $display("FAIL wrap_pp%0d got=%0d/%0b/%h exp=2/1/%h", i, cnt, stx_vld, stx_data, w[i-2]);
            end
        end
        idle();
        for (int i = 4; i < 6; i++) begin
            tx_sync = 1; cyc(); tx_sync = 0;
            total++;
            if (stx_data !== w[i] || stx_data !== m_tdata) begin
                bad++; $display("FAIL wrap_drain%0d got=%h exp=%h", i, stx_data, w[i]);
            end
        end
        tx_sync = 1; cyc(); tx_sync = 0;
        total++; if (stx_vld !== 1'b0 || cnt !== 0) begin bad++; $display("FAIL wrap_end got=%0b/%0d exp=0/0", stx_vld, cnt); end
    endtask

    task automatic test_no_bypass();
        idle();
        tvld = 1; tdata = 8'h5A; tx_sync = 1;
        cyc();
        total++; if (stx_vld !== 1'b0 || cnt !== 3'd1) begin bad++; $display("FAIL bypass_same got=%0b/%0d exp=0/1", stx_vld, cnt); end
        tvld = 0;
        cyc();
        total++; if (stx_vld !== 1'b1 || stx_data !== 8'h5A) begin bad++; $display("FAIL bypass_next got=%0b/%h exp=1/5a", stx_vld, stx_data); end
        idle();
    endtask

    task automatic test_rx();
        idle();
        rx_sync = 1; srx_vld = 1; srx_data = 8'hC3;
        cyc();
        rx_sync = 0; srx_vld = 0; srx_data = 8'h00;
        total++; if (crx_vld !== 1'b1 || crx_data !== 8'hC3) begin bad++; $display("FAIL rx_cap got=%0b/%h exp=1/c3", crx_vld, crx_data); end
        cyc();
        total++; if (crx_vld !== 1'b0 || crx_data !== 8'hC3) begin bad++; $display("FAIL rx_pulse got=%0b/%h exp=0/c3", crx_vld, crx_data); end
        rx_sync = 1; srx_vld = 0; srx_data = 8'h55;
        cyc();
        total++; if (crx_vld !== 1'b0 || crx_data !== 8'hC3) begin bad++; $display("FAIL rx_novld got=%0b/%h exp=0/c3", crx_vld, crx_data); end
        // Back-to-back captures, one with flush asserted to show rx ignores it.
        srx_vld = 1; srx_data = 8'h12; flush = 1;
        cyc();
        total++; if (crx_vld !== 1'b1 || crx_data !== 8'h12) begin bad++; $display("FAIL rx_b2b0 got=%0b/%h exp=1/12", crx_vld, crx_data); end
        flush = 0; srx_data = 8'h34;
        cyc();
        idle();
        total++; if (crx_vld !== 1'b1 || crx_data !== 8'h34) begin bad++; $display("FAIL rx_b2b1 got=%0b/%h exp=1/34", crx_vld, crx_data); end
        cyc();
        total++; if (crx_vld !== 1'b0) begin bad++; $display("FAIL rx_b2b_end got=%0b exp=0", crx_vld); end
    endtask

    task automatic test_flush_reset();
        logic [7:0] held;
        idle();
        for (int i = 0; i < 5; i++) begin tvld = 1; tdata = 8'(8'h60 + i); cyc(); end
        tvld = 0; tx_sync = 1; cyc(); tx_sync = 0;
        held = stx_data;
        total++; if (cnt !== 3'd3 || err !== 1'b1) begin bad++; $display("FAIL fl_pre got=%0d/%0b exp=3/1", cnt, err); end
        flush = 1; tvld = 1; tdata = 8'hEE; tx_sync = 1;
        cyc();
        idle();
        total++;
        if (cnt !== 0 || stx_vld !== 1'b0 || err !== 1'b0 || stx_data !== held) begin
            bad++; $display("FAIL fl_post got=%0d/%0b/%0b/%h exp=0/0/0/%h", cnt, stx_vld, err, stx_data, held);
        end
        tvld = 1; tdata = 8'h71; cyc();
        tdata = 8'h72; tx_sync = 1; rx_sync = 1; srx_vld = 1; srx_data = 8'h99; cyc();
        rst_l = 0; tvld = 1; tx_sync = 1;
        cyc();
        idle();
        total++;
        if ({stx_vld, stx_data, crx_vld, crx_data, err, cnt} !== '0 || rdy !== 1'b1) begin
            bad++; $display("FAIL rst_mid got=%0b/%h/%0b/%h/%0b/%0d/%0b exp=0s rdy=1", stx_vld, stx_data, crx_vld, crx_data, err, cnt, rdy);
        end
    endtask

    task automatic test_random();
        idle();
        for (int k = 0; k < 600; k++) begin
            rst_l    = ($urandom_range(0, 149) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            tx_sync  = ($urandom_range(0, 2) == 0);
            rx_sync  = ($urandom_range(0, 2) == 0);
            tvld     = ($urandom_range(0, 1) == 0);
            tdata    = 8'($urandom);
            srx_vld  = ($urandom_range(0, 3) != 0);
            srx_data = 8'($urandom);
            cyc();
            total++;
            if (stx_vld !== m_tvld || stx_data !== m_tdata || err !== m_err ||
                crx_vld !== m_rvld || crx_data !== m_rdata ||
                cnt !== (PTR_W+1)'(q.size()) || rdy !== (q.size() != DEPTH)) begin
                bad++;
                $display("FAIL rand%0d got=%0b/%h/%0b/%0b/%h/%0d exp=%0b/%h/%0b/%0b/%h/%0d",
                         k, stx_vld, stx_data, err, crx_vld, crx_data, cnt,
                         m_tvld, m_tdata, m_err, m_rvld, m_rdata, q.size());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_launch();
        test_overflow();
        test_wrap();
        test_no_bypass();
        test_rx();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
